// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: data width, counter encodings and default geometry.
// The optional statistics counters are enabled by defining BP_STATS_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package branch_predictor_pkg;

    typedef enum logic [1:0] {
        BP_CTR_SNT = 2'b00,
        BP_CTR_WNT = 2'b01,
        BP_CTR_WT  = 2'b10,
        BP_CTR_ST  = 2'b11
    } bp_ctr_e;

    localparam int BP_DATA_W         = `DATA_WIDTH;
    localparam int BP_DEF_INDEX_BITS = 4;
    localparam int BP_DEF_TAG_BITS   = 8;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and resolve-update bundle between the front end, execute and the predictor.
// Statistics outputs exist only when BP_STATS_EN is defined.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface branch_predictor_if;
    logic [`DATA_WIDTH-1:0] i_pc;
    logic                   o_pred_taken;
    logic [`DATA_WIDTH-1:0] o_pred_target;
    logic                   i_upd_valid;
    logic [`DATA_WIDTH-1:0] i_upd_pc;
    logic                   i_upd_taken;
    logic                   i_upd_is_jump;
    logic [`DATA_WIDTH-1:0] i_upd_target;
    logic                   i_upd_pred_taken;
    logic [`DATA_WIDTH-1:0] i_upd_pred_target;
    logic                   o_mispredict;
`ifdef BP_STATS_EN
    logic [31:0]            o_stat_updates;
    logic [31:0]            o_stat_mispredicts;

    modport master (
        output i_pc, i_upd_valid, i_upd_pc, i_upd_taken, i_upd_is_jump,
               i_upd_target, i_upd_pred_taken, i_upd_pred_target,
        input  o_pred_taken, o_pred_target, o_mispredict,
               o_stat_updates, o_stat_mispredicts
    );

    modport slave (
        input  i_pc, i_upd_valid, i_upd_pc, i_upd_taken, i_upd_is_jump,
               i_upd_target, i_upd_pred_taken, i_upd_pred_target,
        output o_pred_taken, o_pred_target, o_mispredict,
               o_stat_updates, o_stat_mispredicts
    );
`else
    modport master (
        output i_pc, i_upd_valid, i_upd_pc, i_upd_taken, i_upd_is_jump,
               i_upd_target, i_upd_pred_taken, i_upd_pred_target,
        input  o_pred_taken, o_pred_target, o_mispredict
    );

    modport slave (
        input  i_pc, i_upd_valid, i_upd_pc, i_upd_taken, i_upd_is_jump,
               i_upd_target, i_upd_pred_taken, i_upd_pred_target,
        output o_pred_taken, o_pred_target, o_mispredict
    );
`endif
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Next-state function of a 2-bit saturating direction counter; force_strong pins it to strongly taken.
import branch_predictor_pkg::*;

module bp_sat_counter (
    input  logic [1:0] i_ctr,
    input  logic       i_taken,
    input  logic       i_force_strong,
    output logic [1:0] o_ctr
);

    // Saturating increment/decrement with an override for unconditional jumps
    always_comb begin
        o_ctr = i_ctr;
        if (i_force_strong) begin
            o_ctr = BP_CTR_ST;
        end else if (i_taken) begin
            if (i_ctr != BP_CTR_ST) begin
                o_ctr = i_ctr + 2'b01;
            end else begin
                o_ctr = i_ctr;
            end
        end else begin
            if (i_ctr != BP_CTR_SNT) begin
                o_ctr = i_ctr - 2'b01;
            end else begin
                o_ctr = i_ctr;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency lookup, trained by resolved branches.
// Define BP_STATS_EN to add saturating update/mispredict counters.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

import branch_predictor_pkg::*;

module branch_predictor #(
    parameter int         INDEX_BITS = BP_DEF_INDEX_BITS,
    parameter int         TAG_BITS   = BP_DEF_TAG_BITS,
    parameter logic [1:0] CTR_INIT   = BP_CTR_WNT
) (
    input  logic               i_clk,
    input  logic               i_rst,
    branch_predictor_if.slave  bp
);

    localparam int DW      = `DATA_WIDTH;
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_LO  = INDEX_BITS + 2;
    localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

    logic                  r_valid  [ENTRIES];
    logic [1:0]            r_ctr    [ENTRIES];
    logic [TAG_BITS-1:0]   r_tag    [ENTRIES];
    logic [DW-1:0]         r_target [ENTRIES];

    logic [INDEX_BITS-1:0] w_lk_idx;
    logic [TAG_BITS-1:0]   w_lk_tag;
    logic                  w_lk_hit;
    logic                  w_lk_taken;
    logic [INDEX_BITS-1:0] w_up_idx;
    logic [TAG_BITS-1:0]   w_up_tag;
    logic                  w_up_hit;
    logic                  w_alloc;
    logic                  w_train;
    logic [1:0]            w_ctr_next;
    logic                  w_mispredict;
    logic                  w_unused_pc_bits;

    assign w_lk_idx = bp.i_pc[INDEX_BITS+1:2];
    assign w_lk_tag = bp.i_pc[TAG_HI:TAG_LO];
    assign w_up_idx = bp.i_upd_pc[INDEX_BITS+1:2];
    assign w_up_tag = bp.i_upd_pc[TAG_HI:TAG_LO];

    // Byte offset and bits above the tag never take part in the match
    assign w_unused_pc_bits = ^{bp.i_pc[1:0], bp.i_pc[DW-1:TAG_HI+1],
                                bp.i_upd_pc[1:0], bp.i_upd_pc[DW-1:TAG_HI+1]};

    assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_lk_taken = w_lk_hit && r_ctr[w_lk_idx][1];

    assign bp.o_pred_taken  = w_lk_taken;
    assign bp.o_pred_target = w_lk_taken ? r_target[w_lk_idx] : {DW{1'b0}};

    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_train  = bp.i_upd_valid && w_up_hit;
    assign w_alloc  = bp.i_upd_valid && !w_up_hit && bp.i_upd_taken;

    bp_sat_counter u_sat_counter (
        .i_ctr          (r_ctr[w_up_idx]),
        .i_taken        (bp.i_upd_taken),
        .i_force_strong (bp.i_upd_is_jump),
        .o_ctr          (w_ctr_next)
    );

    assign w_mispredict = bp.i_upd_valid &&
                          ((bp.i_upd_taken != bp.i_upd_pred_taken) ||
                           (bp.i_upd_taken && bp.i_upd_pred_taken &&
                            (bp.i_upd_target != bp.i_upd_pred_target)));
    assign bp.o_mispredict = w_mispredict;

    // Valid bits and counters: cleared on reset, trained or allocated on a resolved branch
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= CTR_INIT;
            end
        end else if (w_alloc) begin
            r_valid[w_up_idx] <= 1'b1;
            r_ctr[w_up_idx]   <= bp.i_upd_is_jump ? BP_CTR_ST : BP_CTR_WT;
        end else if (w_train) begin
            r_ctr[w_up_idx] <= w_ctr_next;
        end
    end

    // Tags and targets carry no reset: a cleared valid bit hides whatever they hold
    always_ff @(posedge i_clk) begin
        if (w_alloc) begin
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= bp.i_upd_target;
        end else if (w_train && bp.i_upd_taken) begin
            r_target[w_up_idx] <= bp.i_upd_target;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] r_stat_updates;
    logic [31:0] r_stat_mispredicts;

    // Saturating event counters for resolved branches and mispredictions
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stat_updates     <= 32'd0;
            r_stat_mispredicts <= 32'd0;
        end else begin
            if (bp.i_upd_valid && (r_stat_updates != 32'hFFFF_FFFF)) begin
                r_stat_updates <= r_stat_updates + 32'd1;
            end
            if (w_mispredict && (r_stat_mispredicts != 32'hFFFF_FFFF)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end

    assign bp.o_stat_updates     = r_stat_updates;
    assign bp.o_stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, reset corner cases,
// optional BP_STATS_EN counters, and randomized traffic against a behavioural BTB model.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_branch_predictor;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    branch_predictor_if bp_if ();

    branch_predictor dut (
        .i_clk (clk),
        .i_rst (rst),
        .bp    (bp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] lk_pc;
        logic        uv;
        logic [31:0] upc;
        logic        tk;
        logic        jmp;
        logic [31:0] tgt;
        logic        ptk;
        logic [31:0] ptgt;
        logic        exp_taken;
        logic [31:0] exp_target;
        logic        exp_misp;
    } vec_t;

    vec_t tv[$];

    // behavioural BTB model
    bit          m_valid [16];
    int unsigned m_tag   [16];
    int unsigned m_tgt   [16];
    int          m_ctr   [16];
    int unsigned m_upd_cnt;
    int unsigned m_misp_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] lk, input logic uv, input logic [31:0] upc,
                       input logic tk, input logic jmp, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt,
                       input logic et, input logic [31:0] etg, input logic em);
        vec_t v;
        v = '{lk, uv, upc, tk, jmp, tgt, ptk, ptgt, et, etg, em};
        tv.push_back(v);
    endtask

    task automatic drive(input logic [31:0] lk, input logic uv, input logic [31:0] upc,
                         input logic tk, input logic jmp, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
        bp_if.i_pc              = lk;
        bp_if.i_upd_valid       = uv;
        bp_if.i_upd_pc          = upc;
        bp_if.i_upd_taken       = tk;
        bp_if.i_upd_is_jump     = jmp;
        bp_if.i_upd_target      = tgt;
        bp_if.i_upd_pred_taken  = ptk;
        bp_if.i_upd_pred_target = ptgt;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_upd_cnt  = 0;
        m_misp_cnt = 0;
    endtask

    function automatic logic [31:0] gen_pc();
        logic [31:0] pc;
        pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        pc = pc | ($urandom_range(0, 1) << 20);
        return pc;
    endfunction

    function automatic logic [31:0] gen_tgt();
        return 32'h0000_1000 + ($urandom_range(0, 7) << 2);
    endfunction

    // model lookup in the spec's terms: index = PC[5:2], tag = PC[13:6]
    task automatic model_lookup(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
        int unsigned idx;
        int unsigned tag;
        idx = (pc >> 2) % 16;
        tag = (pc >> 6) % 256;
        tk  = m_valid[idx] && (m_tag[idx] == tag) && (m_ctr[idx] >= 2);
        tg  = tk ? m_tgt[idx] : 32'h0;
    endtask

    task automatic model_update(input logic [31:0] pc, input logic tk, input logic jmp,
                                input logic [31:0] tgt);
        int unsigned idx;
        int unsigned tag;
        idx = (pc >> 2) % 16;
        tag = (pc >> 6) % 256;
        if (m_valid[idx] && m_tag[idx] == tag) begin
            if (jmp)     m_ctr[idx] = 3;
            else if (tk) m_ctr[idx] = (m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1;
            else         m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
            if (tk) m_tgt[idx] = tgt;
        end else if (tk) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
            m_tgt[idx]   = tgt;
            m_ctr[idx]   = jmp ? 3 : 2;
        end
    endtask

    initial begin
        logic        et;
        logic [31:0] etg;
        logic [31:0] upc;
        logic        tk;
        logic        jmp;
        logic [31:0] tgt;
        logic        ptk;
        logic [31:0] ptgt;
        logic        em;

        rst = 1'b1;
        drive(32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #3;
        chk("reset_pred_taken", {31'd0, bp_if.o_pred_taken}, 32'h0);
        chk("reset_pred_target", bp_if.o_pred_target, 32'h0);
        do_reset();

        //  lookup  uv  upc    tk  jmp tgt     ptk ptgt    exp_tk exp_tgt misp
        add(32'h40, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0);
        add(32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1);
        add(32'h40, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h100, 1'b0);
        add(32'h440,1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0);
        add(32'h40, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 32'h100, 1'b1);
        add(32'h40, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0);
        add(32'h40, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0);
        add(32'h40, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0);
        add(32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1);
        add(32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1);
        add(32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0,   1'b1, 32'h100, 1'b1);
        add(32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0);
        add(32'h40, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 32'h100, 1'b1);
        add(32'h40, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h100, 1'b0);
        add(32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 32'h180, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1);
        add(32'h40, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h180, 1'b0);
        add(32'h80, 1'b1, 32'h80, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1);
        add(32'h80, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h200, 1'b0);
        add(32'h40, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0,   1'b1);
        add(32'h80, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h200, 1'b0);
        add(32'h80, 1'b1, 32'hC4, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h200, 1'b0);
        add(32'hC4, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0);
        add(32'h83, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b1, 32'h1,   1'b1, 32'h200, 1'b0);

        foreach (tv[i]) begin
            @(negedge clk);
            drive(tv[i].lk_pc, tv[i].uv, tv[i].upc, tv[i].tk, tv[i].jmp, tv[i].tgt,
                  tv[i].ptk, tv[i].ptgt);
            #1;
            chk($sformatf("tv%0d_taken", i), {31'd0, bp_if.o_pred_taken}, {31'd0, tv[i].exp_taken});
            chk($sformatf("tv%0d_target", i), bp_if.o_pred_target, tv[i].exp_target);
            chk($sformatf("tv%0d_misp", i), {31'd0, bp_if.o_mispredict}, {31'd0, tv[i].exp_misp});
        end

        // asynchronous reset clears a live entry without a clock edge
        @(negedge clk);
        drive(32'h80, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("pre_async_taken", {31'd0, bp_if.o_pred_taken}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_taken", {31'd0, bp_if.o_pred_taken}, 32'h0);
        chk("async_rst_target", bp_if.o_pred_target, 32'h0);
        // update presented while reset is held is discarded
        drive(32'hC4, 1'b1, 32'hC4, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(32'hC4, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("rst_mid_update_taken", {31'd0, bp_if.o_pred_taken}, 32'h0);

`ifdef BP_STATS_EN
        do_reset();
        @(negedge clk); drive(32'h0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0);
        @(negedge clk); drive(32'h0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100);
        @(negedge clk); drive(32'h0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h104, 1'b1, 32'h100);
        @(negedge clk); drive(32'h0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 1'b1, 32'h100);
        @(negedge clk); drive(32'h0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0);
        @(negedge clk); drive(32'h0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0);
        #1;
        chk("stat_updates", bp_if.o_stat_updates, 32'd5);
        chk("stat_mispredicts", bp_if.o_stat_mispredicts, 32'd3);
        rst = 1'b1;
        #1;
        chk("stat_updates_rst", bp_if.o_stat_updates, 32'd0);
        chk("stat_mispredicts_rst", bp_if.o_stat_mispredicts, 32'd0);
`endif

        do_reset();
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            upc = gen_pc();
            tk  = ($urandom_range(0, 2) != 0);
            jmp = tk && ($urandom_range(0, 4) == 0);
            tgt = gen_tgt();
            if ($urandom_range(0, 1) == 1) begin
                model_lookup(upc, ptk, ptgt);
            end else begin
                ptk  = $urandom_range(0, 1);
                ptgt = gen_tgt();
            end
            drive(gen_pc(), ($urandom_range(0, 3) != 0), upc, tk, jmp, tgt, ptk, ptgt);
            #1;
            model_lookup(bp_if.i_pc, et, etg);
            em = bp_if.i_upd_valid && ((tk != ptk) || (tk && ptk && (tgt != ptgt)));
            chk("rnd_taken", {31'd0, bp_if.o_pred_taken}, {31'd0, et});
            chk("rnd_target", bp_if.o_pred_target, etg);
            chk("rnd_misp", {31'd0, bp_if.o_mispredict}, {31'd0, em});
`ifdef BP_STATS_EN
            chk("rnd_stat_upd", bp_if.o_stat_updates, m_upd_cnt);
            chk("rnd_stat_misp", bp_if.o_stat_mispredicts, m_misp_cnt);
            if (bp_if.i_upd_valid) m_upd_cnt++;
            if (em) m_misp_cnt++;
`endif
            if (bp_if.i_upd_valid) model_update(upc, tk, jmp, tgt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Front-end branch predictor: a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Fetch queries it with the current PC; it returns a predicted direction and target.
- The execute stage writes back resolved outcomes (take decision and target from branch resolution) to train entries.
- It sits between the PC-select mux and branch resolution, and is the prediction end of the resolve/redirect path.

Parameters:
- INDEX_BITS, 4, log2 of entry count (16 entries); index = PC[INDEX_BITS+1:2].
- TAG_BITS, 8, tag width; tag = PC[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2].
- CTR_INIT, 2'b01, counter value loaded into every entry at reset (weakly not-taken).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_pc  in  `DATA_WIDTH  fetch PC to look up.
- o_pred_taken  out  1  predicted taken.
- o_pred_target  out  `DATA_WIDTH  predicted target; 0 when o_pred_taken=0.
- i_upd_valid  in  1  resolved control-transfer instruction present this cycle.
- i_upd_pc  in  `DATA_WIDTH  PC of the resolved instruction.
- i_upd_taken  in  1  actual outcome (branch unit take).
- i_upd_is_jump  in  1  instruction is JAL/JALR (unconditional).
- i_upd_target  in  `DATA_WIDTH  actual target address.
- i_upd_pred_taken  in  1  prediction made for this instruction at fetch.
- i_upd_pred_target  in  `DATA_WIDTH  target predicted at fetch.
- o_mispredict  out  1  combinational, valid only when i_upd_valid=1.

Behaviour:
- Storage per entry: valid, tag[TAG_BITS], target[`DATA_WIDTH], ctr[2].
- Reset (async, immediate): all valid=0, all ctr=CTR_INIT, and targets/tags need not be cleared. With no valid entry, o_pred_taken=0 and o_pred_target=0.
- Lookup is combinational (zero latency):
  - hit = valid[idx] && tag[idx]==tag(i_pc).
  - o_pred_taken = hit && ctr[idx][1].
  - o_pred_target = o_pred_taken ? target[idx] : 0.
- Update on the rising i_clk edge when i_upd_valid=1. Taken/not-taken refers to i_upd_taken.
  - Hit, taken: ctr = min(ctr+1, 3); target = i_upd_target.
  - Hit, not-taken: ctr = max(ctr-1, 0); target unchanged; entry stays valid.
  - Miss, taken: allocate by overwriting the index. Set valid=1, tag=tag(i_upd_pc), target=i_upd_target. Set ctr=2'b11 if i_upd_is_jump, else 2'b10.
  - Miss, not-taken: no state change.
  - Hit with i_upd_is_jump=1: ctr forced to 2'b11.
- o_mispredict = i_upd_valid && ((i_upd_taken != i_upd_pred_taken) || (i_upd_taken && i_upd_pred_taken && i_upd_target != i_upd_pred_target)).
- Simultaneous lookup and update to the same index in the same cycle: lookup returns pre-update state (read-before-write). The new value is visible from the next cycle.
- i_upd_valid=0: no storage change; o_mispredict=0.
- PC bits [1:0] are ignored for index and tag.
- Aliasing between PCs that share index and tag is accepted: the prediction may be wrong, and the mispredict path corrects it.
- Reset asserted mid-update: reset wins; the update is discarded.

Optional Feature:
- Macro BP_STATS_EN.
- Defined:
  - Adds outputs o_stat_updates and o_stat_mispredicts, each 32 bits.
  - o_stat_updates increments on each i_upd_valid cycle.
  - o_stat_mispredicts increments when o_mispredict=1.
  - Both saturate at 32'hFFFF_FFFF and are cleared by i_rst.
- Undefined: neither port nor counter exists; the rest of the behaviour is identical.

Decomposition:
- Shared definitions header: `DATA_WIDTH (existing) plus new constants BP_CTR_SNT=2'b00, BP_CTR_WNT=2'b01, BP_CTR_WT=2'b10, BP_CTR_ST=2'b11.
- One natural sub-module, bp_sat_counter: a 2-bit combinational next-state function (ctr, taken, force_strong → next ctr).
- The entry array and stats logic stay in the top module.

Test Plan:
- Reset with i_pc=32'h0000_0040 → o_pred_taken=0, o_pred_target=0.
- Taken branch at PC 0x40 to target 0x100: update taken once, then look up 0x40 → o_pred_taken=1, target 0x100, ctr=10. Same index with a different tag (PC 0x440) → o_pred_taken=0.
- Four not-taken updates after allocation at 0x40: prediction goes not-taken after the first (ctr 10→01), and ctr saturates at 00. Three taken updates return it to 11 and it stays there.
- JAL at 0x80 to 0x200 (is_jump=1, taken): lookup gives taken immediately with ctr=11. One not-taken update → still predicted taken (ctr=10).
- Same-cycle update and lookup at 0x40: lookup shows the old entry; the next cycle shows the new target 0x180.
- With BP_STATS_EN, five updates including two with pred_taken≠taken and one with matching direction but target mismatch → o_stat_updates=5, o_stat_mispredicts=3. Assert i_rst → both read 0 asynchronously.
